ship_ctr_seg_display: RTL and testbench



---
 rtl/ship_ctr_seg_display.sv | 125 ++++++++++++
 tb/tb_ship_ctr_seg_display.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ship_ctr_seg_display.sv
// Four-digit multiplexed seven-segment driver for the ship counters.
// Left pair shows my ships, right pair shows enemy ships; an empty side blinks "0".
module ship_ctr_seg_display #(
    parameter int REFRESH_CYCLES = 65000,
    parameter int BLINK_SLOTS    = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] my_ctr,
    input  logic [3:0] en_ctr,
    input  logic       game_active,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam int BW = $clog2(BLINK_SLOTS) + 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [3:0]    my_q, my_d;
    logic [3:0]    en_q, en_d;
    logic          act_q, act_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic       wrap;
    logic       scan_end;
    logic [3:0] side_ctr;
    logic       is_tens;
    logic       tens;
    logic [3:0] units;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Input snapshot, slot/digit scan and blink timing (blink counts full scans).
    always_comb begin
        my_d     = my_ctr;
        en_d     = en_ctr;
        act_d    = game_active;
        wrap     = (cnt_q == CW'(REFRESH_CYCLES - 1));
        scan_end = wrap && (idx_q == 2'd0);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q - 2'd1 : idx_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        if (scan_end) begin
            if (bcnt_q == BW'(BLINK_SLOTS - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // Segment pattern and anode select for the digit currently being scanned.
    always_comb begin
        side_ctr = idx_q[1] ? my_q : en_q;
        is_tens  = idx_q[0];
        tens     = (side_ctr >= 4'd10);
        units    = tens ? side_ctr - 4'd10 : side_ctr;
        seg_d    = SEG_BLANK;
        if (!act_q) begin
            seg_d = SEG_DASH;
        end else if (side_ctr == 4'd0) begin
            if (!is_tens && phase_q) seg_d = enc(4'd0);
        end else if (is_tens) begin
            if (tens) seg_d = enc(4'd1);
        end else begin
            seg_d = enc(units);
        end
        an_d = ~(4'b0001 << idx_q);
    end

    // All state, with synchronous reset back to the start of a scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            my_q    <= '0;
            en_q    <= '0;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'b1111;
        end else begin
            my_q    <= my_d;
            en_q    <= en_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_ship_ctr_seg_display.sv
// Bench for ship_ctr_seg_display: cycle-level reference model plus
// hand-computed checkpoints, with directed and random counter traffic.
module tb_ship_ctr_seg_display;

    localparam int R = 4;
    localparam int B = 2;

    localparam logic [6:0] BLK  = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;

    logic       clk;
    logic       rst;
    logic [3:0] my_ctr;
    logic [3:0] en_ctr;
    logic       game_active;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    ship_ctr_seg_display #(
        .REFRESH_CYCLES(R),
        .BLINK_SLOTS   (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .my_ctr     (my_ctr),
        .en_ctr     (en_ctr),
        .game_active(game_active),
        .seg        (seg),
        .an         (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] digit_font(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLK;
        endcase
    endfunction

    // What a given digit position must show for a counter value.
    function automatic logic [6:0] show(input int c, input bit tens_pos,
                                        input bit act, input bit ph);
        if (!act) return DASH;
        if (c == 0) return (!tens_pos && ph) ? digit_font(0) : BLK;
        if (tens_pos) return (c >= 10) ? digit_font(1) : BLK;
        return digit_font(c % 10);
    endfunction

    // Reference model: k counts edges since reset release; outputs at an edge
    // reflect the inputs seen on the previous edge.
    bit         mvalid = 0;
    int         k;
    int         s_my, s_en;
    bit         s_act;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    bit         m_phase;
    int         m_dig;

    always @(posedge clk) begin
        if (rst) begin
            mvalid  = 1;
            k       = 0;
            s_my    = 0;
            s_en    = 0;
            s_act   = 0;
            exp_seg = BLK;
            exp_an  = 4'b1111;
            m_phase = 1;
            m_dig   = 3;
        end else if (mvalid) begin
            int slot;
            slot    = k / R;
            m_dig   = 3 - (slot % 4);
            m_phase = (((slot / 4) / B) % 2) == 0;
            exp_an  = 4'b1111;
            exp_an[m_dig] = 1'b0;
            if (m_dig >= 2)
                exp_seg = show(s_my, m_dig == 3, s_act, m_phase);
            else
                exp_seg = show(s_en, m_dig == 1, s_act, m_phase);
            s_my  = int'(my_ctr);
            s_en  = int'(en_ctr);
            s_act = game_active;
            k++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (seg !== exp_seg || an !== exp_an) begin
                errors++;
                $display("FAIL model k=%0d seg=%b an=%b expected seg=%b an=%b",
                         k, seg, an, exp_seg, exp_an);
            end
        end
    end

    task automatic chk(input string name, input logic [10:0] got,
                       input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    // Wait for the first cycle a digit becomes selected.
    task automatic wait_first(input logic [3:0] v);
        logic [3:0] prev;
        bit ok;
        ok   = 0;
        prev = an;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (an == v && prev != v) begin
                ok = 1;
                break;
            end
            prev = an;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for an=%b got=%b", v, an);
        end
    endtask

    initial begin
        rst = 1'b1;
        game_active = 1'b0;
        my_ctr = 4'd0;
        en_ctr = 4'd0;

        // reset and dash scan
        repeat (3) @(negedge clk);
        chk("reset", {seg, an}, {BLK, 4'b1111});
        rst = 1'b0;
        @(negedge clk);
        chk("edge1", {seg, an}, {DASH, 4'b0111});
        repeat (3) @(negedge clk);
        chk("edge4", {seg, an}, {DASH, 4'b0111});
        @(negedge clk);
        chk("edge5", {seg, an}, {DASH, 4'b1011});

        // 12 vs 7
        game_active = 1'b1;
        my_ctr = 4'd12;
        en_ctr = 4'd7;
        wait_first(4'b0111);
        chk("d3_12", {4'd0, seg}, {4'd0, 7'b1111001});
        wait_first(4'b1011);
        chk("d2_12", {4'd0, seg}, {4'd0, 7'b0100100});
        wait_first(4'b1101);
        chk("d1_7", {4'd0, seg}, {4'd0, BLK});
        wait_first(4'b1110);
        chk("d0_7", {4'd0, seg}, {4'd0, 7'b1111000});

        // 9 -> 10 latency on digit 3
        my_ctr = 4'd9;
        wait_first(4'b0111);
        chk("lat_e0", {seg, an}, {BLK, 4'b0111});
        my_ctr = 4'd10;
        @(negedge clk);
        chk("lat_e1", {seg, an}, {BLK, 4'b0111});
        @(negedge clk);
        chk("lat_e2", {seg, an}, {7'b1111001, 4'b0111});

        // enemy empty, my 5
        en_ctr = 4'd0;
        my_ctr = 4'd5;
        wait_first(4'b1011);
        wait_first(4'b1011);
        chk("d2_5", {4'd0, seg}, {4'd0, 7'b0010010});
        repeat (80) @(negedge clk);

        // both empty, then game stops
        my_ctr = 4'd0;
        repeat (70) @(negedge clk);
        for (int n = 0; n < 100 && m_phase; n++) @(negedge clk);
        game_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("dash_ph0", {4'd0, seg}, {4'd0, DASH});
        repeat (10) @(negedge clk);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            my_ctr = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            en_ctr = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            game_active = ($urandom_range(0, 6) != 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        // reset mid-scan with digit 1 selected and blink hidden
        game_active = 1'b1;
        my_ctr = 4'd3;
        en_ctr = 4'd0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 400 && !(m_phase == 0 && m_dig == 1); n++)
            @(negedge clk);
        chk("pre_rst_an", {7'd0, an}, {7'd0, 4'b1101});
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", {seg, an}, {BLK, 4'b1111});
        rst = 1'b0;
        @(negedge clk);
        chk("restart", {seg, an}, {DASH, 4'b0111});
        repeat (28) @(negedge clk);
        chk("blink_on", {seg, an}, {7'b1000000, 4'b1110});
        repeat (16) @(negedge clk);
        chk("blink_off", {seg, an}, {BLK, 4'b1110});
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
